// File: rtl/bju_pipe.sv
// Branch/jump resolution unit: resolves control-flow ops with a 1-cycle registered result,
// issues mispredict redirects and queues BHT/BTB training updates for the BPU.
module bju_pipe #(
    parameter int unsigned PC_WIDTH     = 48,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned TARGET_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH  = 9,
    parameter int unsigned SLOT_BITS    = 2,
    parameter int unsigned UPDQ_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   src1,
    input  logic [DATA_WIDTH-1:0]   src2,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [5:0]              cx_type,
    input  logic                    is_unsigned,
    input  logic                    predict_taken,
    input  logic [TARGET_WIDTH-1:0] predict_target,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   dest,
    output logic                    redirect_valid,
    output logic [PC_WIDTH-1:0]     redirect_target,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [INDEX_WIDTH-1:0]  upd_index,
    output logic [SLOT_BITS-1:0]    upd_slot,
    output logic                    upd_inc,
    output logic                    upd_btb_we,
    output logic [TARGET_WIDTH-1:0] upd_btb_target,
    output logic [CNT_WIDTH-1:0]    perf_branch_cnt,
    output logic [CNT_WIDTH-1:0]    perf_mispred_cnt
);

    localparam int unsigned PTR_W = $clog2(UPDQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_LO = 2 + SLOT_BITS;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0]  index;
        logic [SLOT_BITS-1:0]    slot;
        logic                    inc;
        logic                    btb_we;
        logic [TARGET_WIDTH-1:0] btb_target;
    } upd_t;

    upd_t                   mem_q [UPDQ_DEPTH];
    upd_t                   mem_d [UPDQ_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  dest_q, dest_d;
    logic                   redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0]    redirect_target_q, redirect_target_d;
    logic [CNT_WIDTH-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic                   valid_type, eq, lt, cond, taken, tgt_mis, mispred;
    logic [DATA_WIDTH-1:0]  jalr_sum;
    logic [PC_WIDTH-1:0]    target, pc_plus4;
    logic                   accept, enq, deq;
    upd_t                   entry;

    // Resolve direction, target and mispredict for the presented op.
    always_comb begin
        valid_type = (cx_type != 6'd0) && ((cx_type & (cx_type - 6'd1)) == 6'd0);
        eq         = (src1 == src2);
        lt         = is_unsigned ? (src1 < src2) : ($signed(src1) < $signed(src2));
        cond       = (cx_type[2] & eq) | (cx_type[3] & ~eq) |
                     (cx_type[4] & lt) | (cx_type[5] & ~lt);
        taken      = cx_type[0] | cx_type[1] | cond;
        jalr_sum   = src1 + imm;
        target     = cx_type[1] ? {jalr_sum[PC_WIDTH-1:1], 1'b0}
                                : pc + imm[PC_WIDTH-1:0];
        pc_plus4   = pc + PC_WIDTH'(4);
        tgt_mis    = taken & predict_taken & (predict_target != target[TARGET_WIDTH-1:0]);
        mispred    = valid_type & ((taken & ~predict_taken) | tgt_mis | (~taken & predict_taken));

        entry.index      = pc[IDX_LO+INDEX_WIDTH-1:IDX_LO];
        entry.slot       = pc[IDX_LO-1:2];
        entry.inc        = taken;
        entry.btb_we     = taken & (~predict_taken | tgt_mis);
        entry.btb_target = target[TARGET_WIDTH-1:0];
    end

    assign upd_valid = (cnt_q != CNT_W'(0));
    assign deq       = upd_valid & upd_ready;
    assign in_ready  = (cnt_q != CNT_W'(UPDQ_DEPTH)) | deq;
    assign accept    = in_valid & in_ready & ~flush;
    assign enq       = accept & valid_type;

    // Next-state: update queue, output stage and saturating counters.
    always_comb begin
        mem_d             = mem_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        cnt_d             = cnt_q;
        out_valid_d       = accept;
        redirect_valid_d  = accept & mispred;
        dest_d            = dest_q;
        redirect_target_d = redirect_target_q;
        branch_cnt_d      = branch_cnt_q;
        mispred_cnt_d     = mispred_cnt_q;

        if (enq) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (accept) begin
            dest_d            = DATA_WIDTH'(pc_plus4);
            redirect_target_d = taken ? target : pc_plus4;
        end
        if (enq && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (accept && mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(UPDQ_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            cnt_q             <= '0;
            out_valid_q       <= 1'b0;
            dest_q            <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
            branch_cnt_q      <= '0;
            mispred_cnt_q     <= '0;
        end else begin
            mem_q             <= mem_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            cnt_q             <= cnt_d;
            out_valid_q       <= out_valid_d;
            dest_q            <= dest_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_target_q <= redirect_target_d;
            branch_cnt_q      <= branch_cnt_d;
            mispred_cnt_q     <= mispred_cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign dest             = dest_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_target  = redirect_target_q;
    assign upd_index        = mem_q[rd_ptr_q].index;
    assign upd_slot         = mem_q[rd_ptr_q].slot;
    assign upd_inc          = mem_q[rd_ptr_q].inc;
    assign upd_btb_we       = mem_q[rd_ptr_q].btb_we;
    assign upd_btb_target   = mem_q[rd_ptr_q].btb_target;
    assign perf_branch_cnt  = branch_cnt_q;
    assign perf_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bju_pipe.sv
// Directed bench for bju_pipe: resolution, redirects, update queue, flush, reset, saturation.
module tb_bju_pipe;

    localparam int unsigned PW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 32;
    localparam int unsigned IW = 9;
    localparam int unsigned SB = 2;
    localparam int unsigned QD = 4;
    localparam int unsigned CW = 4;

    localparam logic [5:0] JAL  = 6'b000001;
    localparam logic [5:0] JALR = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b001000;
    localparam logic [5:0] BLT  = 6'b010000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] src1 = '0, src2 = '0, imm = '0;
    logic [PW-1:0] pc = '0;
    logic [5:0]    cx_type = '0;
    logic          is_unsigned = 1'b0;
    logic          predict_taken = 1'b0;
    logic [TW-1:0] predict_target = '0;
    logic          out_valid;
    logic [DW-1:0] dest;
    logic          redirect_valid;
    logic [PW-1:0] redirect_target;
    logic          upd_valid;
    logic          upd_ready = 1'b0;
    logic [IW-1:0] upd_index;
    logic [SB-1:0] upd_slot;
    logic          upd_inc, upd_btb_we;
    logic [TW-1:0] upd_btb_target;
    logic [CW-1:0] perf_branch_cnt, perf_mispred_cnt;

    int total = 0;
    int bad   = 0;

    bju_pipe #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .TARGET_WIDTH(TW), .INDEX_WIDTH(IW),
               .SLOT_BITS(SB), .UPDQ_DEPTH(QD), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .pc(pc), .cx_type(cx_type),
        .is_unsigned(is_unsigned), .predict_taken(predict_taken),
        .predict_target(predict_target), .out_valid(out_valid), .dest(dest),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_slot(upd_slot), .upd_inc(upd_inc), .upd_btb_we(upd_btb_we),
        .upd_btb_target(upd_btb_target), .perf_branch_cnt(perf_branch_cnt),
        .perf_mispred_cnt(perf_mispred_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [5:0] cx, input logic uns, input logic [DW-1:0] s1,
                          input logic [DW-1:0] s2, input logic [DW-1:0] im,
                          input logic [PW-1:0] p, input logic pt, input logic [TW-1:0] ptg);
        cx_type = cx; is_unsigned = uns; src1 = s1; src2 = s2; imm = im;
        pc = p; predict_taken = pt; predict_target = ptg; in_valid = 1'b1;
    endtask

    // Present an op for one clock edge; returns 1 time unit after that edge.
    task automatic send(input logic [5:0] cx, input logic uns, input logic [DW-1:0] s1,
                        input logic [DW-1:0] s2, input logic [DW-1:0] im,
                        input logic [PW-1:0] p, input logic pt, input logic [TW-1:0] ptg);
        set_op(cx, uns, s1, s2, im, p, pt, ptg);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        upd_ready = 1'b1;
        @(posedge clock); #1;
        upd_ready = 1'b0;
    endtask

    task automatic idle();
        @(posedge clock); #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_branch_cnt", 64'(perf_branch_cnt), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle();

        // BEQ equal, predicted not taken -> direction mispredict to target
        send(BEQ, 1'b0, 64'd5, 64'd5, 64'h40, 48'h1000, 1'b0, 32'h0);
        chk("beq_out_valid", 64'(out_valid), 64'd1);
        chk("beq_dest", dest, 64'h1004);
        chk("beq_redir", 64'(redirect_valid), 64'd1);
        chk("beq_redir_tgt", 64'(redirect_target), 64'h1040);
        chk("beq_upd_valid", 64'(upd_valid), 64'd1);
        chk("beq_upd_index", 64'(upd_index), 64'h100);
        chk("beq_upd_slot", 64'(upd_slot), 64'd0);
        chk("beq_upd_inc", 64'(upd_inc), 64'd1);
        chk("beq_upd_btb_we", 64'(upd_btb_we), 64'd1);
        chk("beq_btb_tgt", 64'(upd_btb_target), 64'h1040);
        chk("beq_mispred_cnt", 64'(perf_mispred_cnt), 64'd1);
        pop();
        chk("beq_out_drop", 64'(out_valid), 64'd0);
        chk("beq_redir_drop", 64'(redirect_valid), 64'd0);
        chk("beq_q_empty", 64'(upd_valid), 64'd0);

        // BLT signed taken, correctly predicted; BLTU not taken but predicted taken
        send(BLT, 1'b0, '1, 64'd1, 64'h10, 48'h2000, 1'b1, 32'h2010);
        chk("blt_redir", 64'(redirect_valid), 64'd0);
        chk("blt_upd_inc", 64'(upd_inc), 64'd1);
        chk("blt_upd_btb_we", 64'(upd_btb_we), 64'd0);
        chk("blt_upd_index", 64'(upd_index), 64'h000);
        send(BLT, 1'b1, '1, 64'd1, 64'h10, 48'h2000, 1'b1, 32'h2010);
        chk("bltu_redir", 64'(redirect_valid), 64'd1);
        chk("bltu_redir_tgt", 64'(redirect_target), 64'h2004);
        pop();
        chk("bltu_upd_inc", 64'(upd_inc), 64'd0);
        chk("bltu_upd_btb_we", 64'(upd_btb_we), 64'd0);
        chk("bltu_btb_tgt", 64'(upd_btb_target), 64'h2010);
        pop();
        chk("blt_mispred_cnt", 64'(perf_mispred_cnt), 64'd2);
        chk("blt_branch_cnt", 64'(perf_branch_cnt), 64'd3);

        // JALR target mispredict; bit 0 of the sum is cleared
        send(JALR, 1'b0, 64'h3003, 64'd0, 64'd0, 48'h500, 1'b1, 32'h3000);
        chk("jalr_redir", 64'(redirect_valid), 64'd1);
        chk("jalr_redir_tgt", 64'(redirect_target), 64'h3002);
        chk("jalr_dest", dest, 64'h504);
        chk("jalr_btb_we", 64'(upd_btb_we), 64'd1);
        chk("jalr_btb_tgt", 64'(upd_btb_target), 64'h3002);
        chk("jalr_upd_index", 64'(upd_index), 64'h050);
        pop();

        // Fill the queue with correctly predicted BNEs
        for (int i = 0; i < 4; i++) begin
            send(BNE, 1'b0, 64'd1, 64'd2, 64'd0, 48'(32'h10 + 4 * i), 1'b1, 32'(32'h10 + 4 * i));
            chk("fill_redir", 64'(redirect_valid), 64'd0);
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        set_op(BNE, 1'b0, 64'd1, 64'd2, 64'd0, 48'h20, 1'b1, 32'h20);
        @(posedge clock); #1;
        chk("full_blocked", 64'(out_valid), 64'd0);
        upd_ready = 1'b1;
        #1;
        chk("full_deq_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        upd_ready = 1'b0;
        chk("full_accept", 64'(out_valid), 64'd1);
        chk("full_branch_cnt", 64'(perf_branch_cnt), 64'd9);
        for (int i = 1; i < 4; i++) begin
            chk("order_slot", 64'(upd_slot), 64'(i));
            chk("order_index", 64'(upd_index), 64'h001);
            pop();
        end
        chk("order_last_index", 64'(upd_index), 64'h002);
        chk("order_last_slot", 64'(upd_slot), 64'd0);
        pop();
        chk("order_empty", 64'(upd_valid), 64'd0);

        // Flush drops a presented op; an already-registered result survives its flush cycle
        flush = 1'b1;
        send(BEQ, 1'b0, 64'd5, 64'd5, 64'h40, 48'h1000, 1'b0, 32'h0);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_redir", 64'(redirect_valid), 64'd0);
        chk("flush_q", 64'(upd_valid), 64'd0);
        chk("flush_branch_cnt", 64'(perf_branch_cnt), 64'd9);
        chk("flush_mispred_cnt", 64'(perf_mispred_cnt), 64'd3);
        send(BEQ, 1'b0, 64'd5, 64'd5, 64'h40, 48'h1000, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_hold_valid", 64'(out_valid), 64'd1);
        chk("flush_hold_redir", 64'(redirect_valid), 64'd1);
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_clear_valid", 64'(out_valid), 64'd0);
        chk("flush_keeps_q", 64'(upd_valid), 64'd1);
        pop();

        // Invalid cx_type: result produced, nothing else
        send(6'b000000, 1'b0, 64'd0, 64'd0, 64'd8, 48'h700, 1'b1, 32'h0);
        chk("zero_out_valid", 64'(out_valid), 64'd1);
        chk("zero_dest", dest, 64'h704);
        chk("zero_redir", 64'(redirect_valid), 64'd0);
        chk("zero_q", 64'(upd_valid), 64'd0);
        send(6'b000101, 1'b0, 64'd0, 64'd0, 64'd8, 48'h700, 1'b0, 32'h0);
        chk("multi_redir", 64'(redirect_valid), 64'd0);
        chk("multi_q", 64'(upd_valid), 64'd0);
        chk("multi_branch_cnt", 64'(perf_branch_cnt), 64'd10);

        // Asynchronous reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            send(JAL, 1'b0, 64'd0, 64'd0, 64'd8, 48'h100, 1'b0, 32'h0);
        end
        chk("pre_rst_q", 64'(upd_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_q", 64'(upd_valid), 64'd0);
        chk("mid_rst_branch", 64'(perf_branch_cnt), 64'd0);
        chk("mid_rst_mispred", 64'(perf_mispred_cnt), 64'd0);
        chk("mid_rst_out", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Saturation of both counters (4-bit)
        upd_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(JAL, 1'b0, 64'd0, 64'd0, 64'd8, 48'h100, 1'b0, 32'h0);
        end
        chk("sat_branch_15", 64'(perf_branch_cnt), 64'hF);
        chk("sat_mispred_15", 64'(perf_mispred_cnt), 64'hF);
        send(JAL, 1'b0, 64'd0, 64'd0, 64'd8, 48'h100, 1'b0, 32'h0);
        chk("sat_branch_hold", 64'(perf_branch_cnt), 64'hF);
        chk("sat_mispred_hold", 64'(perf_mispred_cnt), 64'hF);
        chk("sat_redir", 64'(redirect_valid), 64'd1);
        chk("sat_redir_tgt", 64'(redirect_target), 64'h108);
        upd_ready = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bju_pipe.md
Name: bju_pipe

Overview:
- Pipelined, parametrised branch/jump resolution unit for the integer backend.
- Resolves JAL/JALR/BEQ/BNE/BLT/BGE/BLTU/BGEU with a registered output stage, so latency is 1 cycle.
- Detects both direction and target mispredicts and issues the redirect.
- Buffers BHT/BTB training updates in an internal update queue drained by the BPU over a valid/ready handshake; keeps saturating performance counters.

Parameters:
PC_WIDTH, 48, program-counter width
DATA_WIDTH, 64, operand/result width (>= PC_WIDTH)
TARGET_WIDTH, 32, BTB target width stored/compared (<= PC_WIDTH)
INDEX_WIDTH, 9, BHT/BTB set index width
SLOT_BITS, 2, log2 of instructions per fetch set (counter/target slot select)
UPDQ_DEPTH, 4, update queue entries (power of two, >= 2)
CNT_WIDTH, 32, performance counter width

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  kill accepted-but-unissued op and clear output stage
in_valid  in  1  op presented
in_ready  out  1  op may be accepted
src1  in  DATA_WIDTH  rs1 value
src2  in  DATA_WIDTH  rs2 value
imm  in  DATA_WIDTH  sign-extended immediate
pc  in  PC_WIDTH  op PC
cx_type  in  6  one-hot: [0]JAL [1]JALR [2]BEQ [3]BNE [4]BLT(U) [5]BGE(U)
is_unsigned  in  1  selects BLTU/BGEU for bits 4/5
predict_taken  in  1  BPU direction prediction
predict_target  in  TARGET_WIDTH  BPU target prediction
out_valid  out  1  result valid (registered)
dest  out  DATA_WIDTH  link value pc+4, zero-extended
redirect_valid  out  1  mispredict redirect (registered, one-cycle pulse per op)
redirect_target  out  PC_WIDTH  correct next PC
upd_valid  out  1  queue head valid
upd_ready  in  1  BPU consumes head
upd_index  out  INDEX_WIDTH  pc[2+SLOT_BITS+INDEX_WIDTH-1 : 2+SLOT_BITS]
upd_slot  out  SLOT_BITS  pc[2+SLOT_BITS-1 : 2]
upd_inc  out  1  1 = increment counter, 0 = decrement
upd_btb_we  out  1  write upd_btb_target into BTB slot
upd_btb_target  out  TARGET_WIDTH  resolved target low bits
perf_branch_cnt  out  CNT_WIDTH  resolved control-flow ops
perf_mispred_cnt  out  CNT_WIDTH  redirects issued

Behaviour:
- Accept = in_valid & in_ready & ~flush. in_ready = ~q_full | (upd_valid & upd_ready), so enqueue and dequeue may occur in the same cycle when full.
- Compare rules:
  - signed less-than uses two's-complement over DATA_WIDTH.
  - unsigned uses a plain magnitude compare.
  - BGE/BGEU = ~less-than.
- Target:
  - JALR: (src1+imm) with bit 0 cleared, truncated to PC_WIDTH.
  - Others: pc+imm truncated to PC_WIDTH.
  - Wrap-around is modulo 2^PC_WIDTH.
- taken = JAL | JALR | (branch & condition).
- Mispredict and redirect:
  - Target mispredict: taken & predict_taken & (predict_target != target[TARGET_WIDTH-1:0]) -> redirect to target.
  - Direction mispredict, taken: taken & ~predict_taken -> redirect to target.
  - Direction mispredict, not taken: ~taken & predict_taken -> redirect to pc+4.
  - Correct prediction: no redirect.
- Update entry, enqueued at accept for every op with exactly one cx_type bit set:
  - upd_inc = taken.
  - upd_btb_we = taken & (~predict_taken | target mispredict).
  - upd_btb_target = target[TARGET_WIDTH-1:0].
- cx_type zero or multi-hot:
  - op accepted; out_valid and dest still produced.
  - no redirect, no enqueue, no counter change.
- Output stage:
  - Registered on accept; the cycle after accept it presents out_valid=1, dest, redirect_valid and redirect_target.
  - With no accept it deasserts out_valid/redirect_valid next cycle; there is no output backpressure.
- Queue:
  - FIFO, head presented combinationally.
  - Pointers wrap modulo UPDQ_DEPTH; count 0..UPDQ_DEPTH.
  - Dequeue when empty is ignored.
  - Contents survive flush (training is non-speculative for resolved ops).
- Flush:
  - Op presented in the same cycle is dropped: no enqueue, no output, no count.
  - Next cycle out_valid=0 and redirect_valid=0.
  - A result already on the outputs in the flush cycle remains valid for that cycle.
- Counters:
  - perf_branch_cnt +1 per accepted valid-type op.
  - perf_mispred_cnt +1 per redirect.
  - Both saturate at all-ones.
- Reset (asynchronous, any time): queue empty, all registered outputs 0, counters 0. in_ready=1 while queue empty.

Test Plan:
- BEQ, src1=src2=5, pc=0x1000, imm=0x40, predict_taken=0 -> next cycle redirect_valid=1, target=0x1040; queue entry index=0x100, slot=0, inc=1, btb_we=1, btb_target=0x1040; perf_mispred_cnt=1.
- BLT signed, src1=-1, src2=1, predict_taken=1, predict_target=0x2010, pc=0x2000, imm=0x10 -> no redirect; inc=1, btb_we=0. Same operands as BLTU predicted taken -> redirect to 0x2004, inc=0.
- JALR, src1=0x3003, imm=0, predict_taken=1, predict_target=0x3000, pc=0x500 -> target 0x3002 mismatches prediction, so redirect_valid=1 to 0x3002, btb_we=1; dest=0x504.
- Hold upd_ready=0, send 4 branches -> in_ready=0 after the 4th. Raise upd_ready with a 5th op pending -> accepted in the same cycle; FIFO order preserved.
- Assert flush together with in_valid -> no out_valid, no queue growth, counters unchanged. Assert reset mid-stream with queue at 3 -> upd_valid=0, counters 0 immediately.
- Preload counters near all-ones (force or a long run) -> perf_branch_cnt holds at all-ones, no wrap.
